mux_arb_reg: RTL and testbench

- Parametrised N-input, W-bit selector. Next generation of the team's 4:1 tri-state mux.
- Adds a registered output stage with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - Explicit select: the channel is chosen by a sel port, as in the combinational mux.
  - Round-robin: the block arbitrates among requesting channels.
- Sits between multiple ALU operand/result producers and a single consumer. Replaces the tri-state 4:1 mux where back-pressure is needed.

---
 rtl/mux_arb_reg.sv | 111 +++++++++++
 tb/tb_mux_arb_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-input, W-bit selector with a registered valid/ready output stage.
// Channels are picked by an explicit index (mode 0) or by round-robin arbitration (mode 1).
module mux_arb_reg #(
    parameter int w = 16,
    parameter int n = 4,
    localparam int sw = $clog2(n)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n*w-1:0]   in_data,
    input  logic [n-1:0]     in_valid,
    output logic [n-1:0]     in_ready,
    input  logic             mode,
    input  logic [sw-1:0]    sel,
    output logic [w-1:0]     out_data,
    output logic [sw-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic          load_en;
    logic          sel_hit;
    logic          rr_hit;
    logic [sw-1:0] rr_grant;
    logic          grant_valid;
    logic [sw-1:0] grant;
    logic [w-1:0]  grant_data;
    logic [sw-1:0] rr_ptr;
    logic [sw-1:0] rr_next;
    logic          in_xfer;

    // The register accepts a new word when empty or when it is being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        sel_hit = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (sel == sw'(k) && in_valid[k]) begin
                sel_hit = 1'b1;
            end
        end
    end

    // Round-robin search: channels at or above rr_ptr take priority over the wrapped-around ones,
    // and within each half the lowest index wins, giving the upward search with wrap n-1 -> 0.
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        for (int k = n - 1; k >= 0; k--) begin
            if (in_valid[k] && sw'(k) < rr_ptr) begin
                rr_hit   = 1'b1;
                rr_grant = sw'(k);
            end
        end
        for (int k = n - 1; k >= 0; k--) begin
            if (in_valid[k] && sw'(k) >= rr_ptr) begin
                rr_hit   = 1'b1;
                rr_grant = sw'(k);
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_valid = rr_hit;
            grant       = rr_grant;
        end else begin
            grant_valid = sel_hit;
            grant       = sel;
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < n; k++) begin
            if (grant == sw'(k)) begin
                grant_data  = in_data[k*w +: w];
                in_ready[k] = grant_valid && load_en;
            end
        end
    end

    assign in_xfer = grant_valid && load_en;

    // Explicit wrap keeps the pointer inside 0..n-1 for non-power-of-2 n.
    assign rr_next = (grant == sw'(n - 1)) ? '0 : grant + sw'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant;
                if (mode) begin
                    rr_ptr <= rr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: a 4-channel instance and a 3-channel instance
// driven by directed vector tables plus a hand-written asynchronous reset sequence.
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [63:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic        a_mode;
    logic [1:0]  a_sel;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_chan;
    logic        a_out_valid;
    logic        a_out_ready;

    // 3-channel instance
    logic [47:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_chan;
    logic        b_out_valid;
    logic        b_out_ready;

    mux_arb_reg #(.w(16), .n(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .sel(a_sel),
        .out_data(a_out_data), .out_chan(a_out_chan),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_arb_reg #(.w(16), .n(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel),
        .out_data(b_out_data), .out_chan(b_out_chan),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_v;
        logic [1:0]  exp_c;
        logic [15:0] exp_d;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                                input logic ordy, input logic [3:0] rdy, input logic v,
                                input logic [1:0] c, input logic [15:0] d);
        vec_t r;
        r.mode = m; r.sel = s; r.iv = iv; r.ordy = ordy;
        r.exp_rdy = rdy; r.exp_v = v; r.exp_c = c; r.exp_d = d;
        return r;
    endfunction

    // Called at posedge+1: drive, check in_ready mid-cycle, then check registered outputs after the edge.
    task automatic run_vec(input vec_t v, input bit on_b, input string tag);
        if (on_b) begin
            b_mode = v.mode; b_sel = v.sel; b_in_valid = v.iv[2:0]; b_out_ready = v.ordy;
        end else begin
            a_mode = v.mode; a_sel = v.sel; a_in_valid = v.iv; a_out_ready = v.ordy;
        end
        #2;
        if (on_b) check({tag, " in_ready"}, 32'(b_in_ready), 32'(v.exp_rdy[2:0]));
        else      check({tag, " in_ready"}, 32'(a_in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        if (on_b) begin
            check({tag, " out_valid"}, 32'(b_out_valid), 32'(v.exp_v));
            check({tag, " out_chan"},  32'(b_out_chan),  32'(v.exp_c));
            check({tag, " out_data"},  32'(b_out_data),  32'(v.exp_d));
        end else begin
            check({tag, " out_valid"}, 32'(a_out_valid), 32'(v.exp_v));
            check({tag, " out_chan"},  32'(a_out_chan),  32'(v.exp_c));
            check({tag, " out_data"},  32'(a_out_data),  32'(v.exp_d));
        end
    endtask

    initial begin
        a_in_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        b_in_data = {16'h2002, 16'h2001, 16'h2000};
        a_in_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b1;
        b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;

        // ---- 4-channel table ----
        for (int i = 0; i < 2; i++) va.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 16'h0000));
        for (int i = 0; i < 3; i++) va.push_back(mk(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 16'h1002));
        va.push_back(mk(0, 2, 4'b1011, 1, 4'b0000, 0, 2, 16'h1002));
        for (int i = 0; i < 8; i++)
            va.push_back(mk(1, 0, 4'b1111, 1, 4'(1 << (i % 4)), 1, 2'(i % 4), 16'h1000 + 16'(i % 4)));
        for (int i = 0; i < 2; i++) begin
            va.push_back(mk(1, 0, 4'b1010, 1, 4'b0010, 1, 1, 16'h1001));
            va.push_back(mk(1, 0, 4'b1010, 1, 4'b1000, 1, 3, 16'h1003));
        end
        va.push_back(mk(1, 0, 4'b0001, 1, 4'b0001, 1, 0, 16'h1000));
        va.push_back(mk(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 16'h1001));
        for (int i = 0; i < 3; i++) va.push_back(mk(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 16'h1001));
        va.push_back(mk(1, 0, 4'b1111, 1, 4'b0100, 1, 2, 16'h1002));
        va.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 0, 2, 16'h1002));
        va.push_back(mk(0, 0, 4'b0001, 0, 4'b0001, 1, 0, 16'h1000));
        va.push_back(mk(0, 0, 4'b0001, 0, 4'b0000, 1, 0, 16'h1000));
        va.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0, 16'h1000));

        // ---- 3-channel table ----
        for (int i = 0; i < 4; i++)
            vb.push_back(mk(1, 0, 4'b0111, 1, 4'(1 << (i % 3)), 1, 2'(i % 3), 16'h2000 + 16'(i % 3)));
        for (int i = 0; i < 2; i++) vb.push_back(mk(0, 1, 4'b0111, 1, 4'b0010, 1, 1, 16'h2001));
        vb.push_back(mk(1, 0, 4'b0111, 1, 4'b0010, 1, 1, 16'h2001));
        vb.push_back(mk(1, 0, 4'b0111, 1, 4'b0100, 1, 2, 16'h2002));
        vb.push_back(mk(1, 0, 4'b0111, 1, 4'b0001, 1, 0, 16'h2000));
        for (int i = 0; i < 2; i++) vb.push_back(mk(0, 3, 4'b0111, 1, 4'b0000, 0, 0, 16'h2000));
        vb.push_back(mk(0, 2, 4'b0011, 1, 4'b0000, 0, 0, 16'h2000));

        // ---- reset state ----
        #12;
        check("reset out_valid", 32'(a_out_valid), 32'd0);
        check("reset out_data",  32'(a_out_data),  32'd0);
        check("reset out_chan",  32'(a_out_chan),  32'd0);
        check("reset b out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- load two words round-robin, then reset asynchronously mid-cycle ----
        a_mode = 1'b1; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset out_valid", 32'(a_out_valid), 32'd1);
        check("pre-reset out_chan",  32'(a_out_chan),  32'd1);
        a_in_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(a_out_valid), 32'd0);
        check("async reset out_data",  32'(a_out_data),  32'd0);
        check("async reset out_chan",  32'(a_out_chan),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle %0d out_valid", i), 32'(a_out_valid), 32'd0);
        end

        foreach (va[i]) run_vec(va[i], 1'b0, $sformatf("a[%0d]", i));
        foreach (vb[i]) run_vec(vb[i], 1'b1, $sformatf("b[%0d]", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
